// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU types. This slice holds the instruction cache definitions:
//   ICACHE_SETS     default number of frames in the instruction cache
//   ICACHE_IDX_W    index width derived from ICACHE_SETS
//   ICACHE_TAG_W    tag width derived from ICACHE_SETS (addr[31:2+IDX_W])
//   icache_state_t  miss-handling FSM states
//   icache_frame_t  one cache frame {valid, tag, data}
//   icache_tag()    extracts the tag field of a byte address
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  // Tag is everything above the word offset and the index. The result is
  // sized to the frame's tag field, so a cache built with more frames than
  // ICACHE_SETS just carries leading zeros in the stored tag.
  function automatic logic [ICACHE_TAG_W-1:0] icache_tag(input logic [31:0] addr,
                                                         input int         idx_w);
    return ICACHE_TAG_W'(addr >> (2 + idx_w));
  endfunction

endpackage

// File: rtl/icache_frames.sv
// icache_frames
// Frame storage for the direct-mapped instruction cache: SETS frames of
// {valid, tag, data}, one synchronous write port, one combinational read port
// and a global invalidate that clears only the valid bits.
// Ports:
//   CLK     clock, rising edge
//   nRST    synchronous active-low reset, clears every field of every frame
//   inv     clear all valid bits this edge (tag/data untouched)
//   wen     write wframe into frame widx this edge
//   widx    write index
//   wframe  frame contents to write
//   ridx    read index
//   rframe  frame at ridx, combinational
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inv,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  icache_frame_t    wframe,
  input  logic [IDX_W-1:0] ridx,
  output icache_frame_t    rframe
);

  icache_frame_t frames [SETS];

  // Invalidate beats a write in the same cycle; the controller never asks for
  // both at once, but the frame array stays safe even if it did.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        frames[i] <= '0;
      end
    end else if (inv) begin
      for (int i = 0; i < SETS; i++) begin
        frames[i].valid <= 1'b0;
      end
    end else if (wen) begin
      frames[widx] <= wframe;
    end
  end

  assign rframe = frames[ridx];

endmodule

// File: rtl/icache_responder.sv
// icache_responder
// Direct-mapped, read-only instruction cache with one 32-bit word per frame.
// Hits return data in the same cycle; misses stall the datapath (ihit=0)
// while a two-state FSM fetches the word from the memory controller.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters.
// Ports:
//   CLK, nRST             clock and synchronous active-low reset
//   imemREN, imemaddr     fetch request from the datapath
//   ihit, imemload        fetch data valid / instruction (0 when no hit)
//   iREN, iaddr           fill request to the memory controller
//   iwait, iload          memory busy flag / fill data
//   inv                   invalidate all frames, aborts an in-flight fill
//   hit_count, miss_count statistics (ICACHE_STATS_EN only)
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        inv
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  icache_state_t    state, next_state;
  logic [31:0]      miss_addr;
  logic             miss_start;
  logic             fill_wen;
  logic             hit;
  logic [IDX_W-1:0] req_idx;
  icache_frame_t    rd_frame;
  icache_frame_t    fill_frame;

  assign req_idx = imemaddr[1+IDX_W:2];

  icache_frames #(
    .SETS(SETS)
  ) u_frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .inv   (inv),
    .wen   (fill_wen),
    .widx  (miss_addr[1+IDX_W:2]),
    .wframe(fill_frame),
    .ridx  (req_idx),
    .rframe(rd_frame)
  );

  // A hit is only reported from IDLE, and inv masks it so the datapath never
  // consumes a word from a frame that is being invalidated this edge.
  assign hit = (state == IDLE) && imemREN && !inv && rd_frame.valid
               && (rd_frame.tag == icache_tag(imemaddr, IDX_W));

  assign ihit     = hit;
  assign imemload = hit ? rd_frame.data : 32'h0;
  assign iREN     = (state == FETCH);
  assign iaddr    = iREN ? miss_addr : 32'h0;

  assign fill_frame.valid = 1'b1;
  assign fill_frame.tag   = icache_tag(miss_addr, IDX_W);
  assign fill_frame.data  = iload;

  // State register; reset abandons any fill in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. In FETCH, inv is checked before iwait so a word that
  // arrives in the same cycle as an invalidate is dropped, not written.
  always_comb begin
    next_state = state;
    miss_start = 1'b0;
    fill_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (!inv && imemREN && !hit) begin
          next_state = FETCH;
          miss_start = 1'b1;
        end
      end
      FETCH: begin
        if (inv) begin
          next_state = IDLE;
        end else if (!iwait) begin
          fill_wen   = 1'b1;
          next_state = IDLE;
        end
      end
    endcase
  end

  // The miss address is latched once at FETCH entry so the datapath may move
  // imemaddr freely while the fill is outstanding.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      miss_addr <= 32'h0;
    end else if (miss_start) begin
      miss_addr <= {imemaddr[31:2], 2'b00};
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating statistics; only reset clears them, inv leaves them alone.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder
// Directed bench for icache_responder. Expected fetch data and fill addresses
// are queued when a request is issued; monitors pop and compare whenever the
// cache presents ihit or starts a fill. Build with ICACHE_STATS_EN to also
// exercise the statistics counters.
module tb_icache_responder;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        inv;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks;
  int errors;
  int mem_lat;
  int mem_cnt;
  bit mon_en;
  bit iren_prev;

  logic [31:0] hit_q  [$];
  logic [31:0] fill_q [$];

  icache_responder dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .inv       (inv)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory image: hand-picked so address 0 holds 0x0010_0093.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'h0010_0093 + (a << 8);
  endfunction

  // Memory controller model: holds iwait high for mem_lat cycles of a
  // continuous request, then returns the word with iwait low.
  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      if (mem_cnt >= mem_lat) begin
        iwait = 1'b0;
        iload = memval(iaddr);
      end else begin
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
      end
      mem_cnt++;
    end else begin
      mem_cnt = 0;
      iwait   = 1'b1;
      iload   = 32'hDEAD_BEEF;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fetch data monitor.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (ihit === 1'b1) begin
        if (hit_q.size() == 0) begin
          checkOutput("unexpected_ihit", imemload, 32'hXXXX_XXXX);
        end else begin
          checkOutput("imemload", imemload, hit_q.pop_front());
        end
      end else begin
        checkOutput("imemload_nohit", imemload, 32'h0);
      end
    end
  end

  // Fill request monitor: each new request must match the next queued address.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (iREN === 1'b1 && !iren_prev) begin
        if (fill_q.size() == 0) begin
          checkOutput("unexpected_fill", iaddr, 32'hXXXX_XXXX);
        end else begin
          checkOutput("fill_iaddr", iaddr, fill_q.pop_front());
        end
      end else if (iREN !== 1'b1) begin
        checkOutput("iaddr_idle", iaddr, 32'h0);
      end
      iren_prev = (iREN === 1'b1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue a fetch and wait (bounded) for ihit; leaves imemREN asserted so
  // consecutive calls give back-to-back fetches.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_data,
                               input bit is_miss, input int exp_lat, input string name);
    int n;
    n        = 0;
    imemREN  = 1'b1;
    imemaddr = addr;
    if (is_miss) fill_q.push_back({addr[31:2], 2'b00});
    hit_q.push_back(exp_data);
    @(negedge CLK);
    while (ihit !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mem_lat  = 2;
    mem_cnt  = 0;
    mon_en   = 1'b0;
    iren_prev = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;
    inv      = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    nRST     = 1'b0;

    // Reset with a request pending: nothing may start.
    tick();
    tick();
    checkOutput("rst_ihit", {31'h0, ihit}, 32'h0);
    checkOutput("rst_imemload", imemload, 32'h0);
    checkOutput("rst_iREN", {31'h0, iREN}, 32'h0);
    checkOutput("rst_iaddr", iaddr, 32'h0);
    imemREN = 1'b0;
    nRST    = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Cold miss on 0x0 with L=2, then hits on the same word.
    $display("[TB] cold miss");
    applyStimulus(32'h0, 32'h0010_0093, 1'b1, 4, "cold_miss");
    applyStimulus(32'h0, 32'h0010_0093, 1'b0, 0, "hit1");
    applyStimulus(32'h0, 32'h0010_0093, 1'b0, 0, "hit2");
    applyStimulus(32'h0, 32'h0010_0093, 1'b0, 0, "hit3");
    applyStimulus(32'h0, 32'h0010_0093, 1'b0, 0, "hit4");
    imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
    checkOutput("hit_count", hit_count, 32'd5);
    checkOutput("miss_count", miss_count, 32'd1);
    force dut.hit_count = 32'hFFFF_FFFF;
    tick();
    release dut.hit_count;
    applyStimulus(32'h0, 32'h0010_0093, 1'b0, 0, "sat_hit");
    imemREN = 1'b0;
    checkOutput("hit_count_sat", hit_count, 32'hFFFF_FFFF);
    checkOutput("miss_count_hold", miss_count, 32'd1);
`endif
    tick();

    // Conflict on index 1: 0x4 and 0x44 evict each other; frame 0 survives.
    $display("[TB] conflict");
    applyStimulus(32'h4,  32'h0010_0493, 1'b1, 4, "fill_4");
    applyStimulus(32'h44, 32'h0010_4493, 1'b1, 4, "conflict_44");
    applyStimulus(32'h4,  32'h0010_0493, 1'b1, 4, "refill_4");
    applyStimulus(32'h0,  32'h0010_0093, 1'b0, 0, "frame0_kept");
    imemREN = 1'b0;
    tick();

    // Address change mid-fill: 0x8 still filled, then 0xC misses.
    $display("[TB] address change during fill");
    begin
      int n;
      n        = 0;
      imemREN  = 1'b1;
      imemaddr = 32'h8;
      fill_q.push_back(32'h8);
      tick();
      imemaddr = 32'hC;
      fill_q.push_back(32'hC);
      hit_q.push_back(32'h0010_0C93);
      @(negedge CLK);
      while (ihit !== 1'b1 && n < 40) begin
        @(negedge CLK);
        n++;
      end
      checkOutput("addr_change_latency", 32'(n), 32'd7);
      tick();
    end
    applyStimulus(32'h8, 32'h0010_0893, 1'b0, 0, "frame2_for_8");
    imemREN = 1'b0;
    tick();

    // inv in the same cycle the fill data arrives: fill discarded.
    $display("[TB] invalidate during fetch");
    imemREN  = 1'b1;
    imemaddr = 32'h10;
    fill_q.push_back(32'h10);
    tick();
    tick();
    tick();
    inv     = 1'b1;
    imemREN = 1'b0;
    @(negedge CLK);
    checkOutput("inv_fetch_active", {31'h0, iREN}, 32'h1);
    tick();
    inv = 1'b0;
    @(negedge CLK);
    checkOutput("inv_abort_iREN", {31'h0, iREN}, 32'h0);
    tick();
    applyStimulus(32'h10, 32'h0010_1093, 1'b1, 4, "after_abort_10");
    imemREN = 1'b0;
    tick();

    // inv with a fetch of a valid word: no hit, no miss that cycle.
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    inv      = 1'b1;
    @(negedge CLK);
    checkOutput("inv_masks_ihit", {31'h0, ihit}, 32'h0);
    tick();
    inv     = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    checkOutput("inv_no_miss", {31'h0, iREN}, 32'h0);
    tick();
    applyStimulus(32'h0, 32'h0010_0093, 1'b1, 4, "post_inv_0");
    applyStimulus(32'h4, 32'h0010_0493, 1'b1, 4, "post_inv_4");
    imemREN = 1'b0;
    tick();

    // Zero-latency memory: penalty is exactly two cycles.
    mem_lat = 0;
    applyStimulus(32'h30, 32'h0010_3093, 1'b1, 2, "lat0_30");
    imemREN = 1'b0;
    mem_lat = 2;
    tick();

    // Reset in the middle of a fill.
    $display("[TB] reset during fetch");
    imemREN  = 1'b1;
    imemaddr = 32'h20;
    fill_q.push_back(32'h20);
    tick();
    nRST    = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_iREN_pre", {31'h0, iREN}, 32'h1);
    tick();
    @(negedge CLK);
    checkOutput("midrst_iREN", {31'h0, iREN}, 32'h0);
    checkOutput("midrst_iaddr", iaddr, 32'h0);
    checkOutput("midrst_ihit", {31'h0, ihit}, 32'h0);
    tick();
    nRST = 1'b1;
    tick();
    applyStimulus(32'h0,  32'h0010_0093, 1'b1, 4, "post_rst_0");
    applyStimulus(32'h20, 32'h0010_2093, 1'b1, 4, "post_rst_20");
    imemREN = 1'b0;
    tick();
    tick();

    checkOutput("hit_q_empty", 32'(hit_q.size()), 32'd0);
    checkOutput("fill_q_empty", 32'(fill_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
